// File: rtl/fpu_issue_arbiter.sv
// rtl/fpu_issue_arbiter.sv - round-robin issue arbiter for one shared pipelined FPU unit
// Registers the winning operands into the unit and routes results back by tag.
module fpu_issue_arbiter #(
    parameter int N_REQ = 2,
    parameter int W     = 32,
    parameter int LAT   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     i_req_valid,
    input  logic [N_REQ*W-1:0]   i_req_a,
    input  logic [N_REQ*W-1:0]   i_req_b,
    output logic [N_REQ-1:0]     o_req_ready,
    input  logic                 i_issue_en,
    output logic [W-1:0]         o_unit_a,
    output logic [W-1:0]         o_unit_b,
    output logic                 o_unit_valid,
    input  logic [W-1:0]         i_unit_result,
    input  logic                 i_unit_out_valid,
    output logic [N_REQ-1:0]     o_rsp_valid,
    output logic [W-1:0]         o_rsp_data,
    output logic                 o_busy,
    output logic                 o_err_seq
);

    localparam int IDW = $clog2(N_REQ);

    logic [IDW-1:0]   r_ptr;
    logic [W-1:0]     r_unit_a;
    logic [W-1:0]     r_unit_b;
    logic             r_unit_valid;
    logic [IDW-1:0]   r_unit_id;
    logic [LAT-1:0]   r_tag_v;
    logic [IDW-1:0]   r_tag_id [LAT];
    logic [N_REQ-1:0] r_rsp_valid;
    logic [W-1:0]     r_rsp_data;
    logic             r_err_seq;

    logic [IDW:0]     w_scan;
    logic             w_found;
    logic [IDW-1:0]   w_grant_id;
    logic [N_REQ-1:0] w_grant;
    logic [IDW-1:0]   w_ptr_next;
    logic [W-1:0]     w_sel_a;
    logic [W-1:0]     w_sel_b;
    logic [N_REQ-1:0] w_head_onehot;
    logic             w_head_v;

    // Scan from the pointer upward, wrapping, and take the first active request.
    always_comb begin
        w_grant    = '0;
        w_grant_id = '0;
        w_found    = 1'b0;
        w_scan     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_scan = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_scan >= (IDW+1)'(N_REQ))
                w_scan = w_scan - (IDW+1)'(N_REQ);
            if (!w_found && i_issue_en && i_req_valid[w_scan[IDW-1:0]]) begin
                w_found    = 1'b1;
                w_grant_id = w_scan[IDW-1:0];
            end
        end
        if (w_found)
            w_grant[w_grant_id] = 1'b1;
    end

    assign w_ptr_next = (w_grant_id == IDW'(N_REQ-1)) ? '0 : w_grant_id + 1'b1;
    assign w_sel_a    = i_req_a[int'(w_grant_id)*W +: W];
    assign w_sel_b    = i_req_b[int'(w_grant_id)*W +: W];
    assign w_head_v   = r_tag_v[LAT-1];

    always_comb begin
        w_head_onehot = '0;
        w_head_onehot[r_tag_id[LAT-1]] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr        <= '0;
            r_unit_a     <= '0;
            r_unit_b     <= '0;
            r_unit_valid <= 1'b0;
            r_unit_id    <= '0;
            r_tag_v      <= '0;
            for (int i = 0; i < LAT; i++)
                r_tag_id[i] <= '0;
            r_rsp_valid  <= '0;
            r_rsp_data   <= '0;
            r_err_seq    <= 1'b0;
        end else begin
            r_unit_valid <= w_found;
            if (w_found) begin
                r_unit_a  <= w_sel_a;
                r_unit_b  <= w_sel_b;
                r_unit_id <= w_grant_id;
                r_ptr     <= w_ptr_next;
            end
            // Tag pipe mirrors the unit latency; the last stage lines up with its result strobe.
            r_tag_v[0]  <= r_unit_valid;
            r_tag_id[0] <= r_unit_id;
            for (int i = 1; i < LAT; i++) begin
                r_tag_v[i]  <= r_tag_v[i-1];
                r_tag_id[i] <= r_tag_id[i-1];
            end
            if (i_unit_out_valid && w_head_v) begin
                r_rsp_valid <= w_head_onehot;
                r_rsp_data  <= i_unit_result;
            end else begin
                r_rsp_valid <= '0;
            end
            if (i_unit_out_valid != w_head_v)
                r_err_seq <= 1'b1;
        end
    end

    assign o_req_ready  = w_grant;
    assign o_unit_a     = r_unit_a;
    assign o_unit_b     = r_unit_b;
    assign o_unit_valid = r_unit_valid;
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_data   = r_rsp_data;
    assign o_busy       = r_unit_valid | (|r_tag_v);
    assign o_err_seq    = r_err_seq;

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// tb/tb_fpu_issue_arbiter.sv - self-checking bench for fpu_issue_arbiter
// Cycle tables for arbitration/issue/drain plus directed error and reset sequences.
module tb_fpu_issue_arbiter;
    localparam int N_REQ = 2;
    localparam int W     = 32;
    localparam int LAT   = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [N_REQ-1:0]   req_valid = '0;
    logic [N_REQ*W-1:0] req_a = '0;
    logic [N_REQ*W-1:0] req_b = '0;
    logic [N_REQ-1:0]   req_ready;
    logic               issue_en = 1'b0;
    logic [W-1:0]       unit_a, unit_b;
    logic               unit_valid;
    logic [W-1:0]       unit_result;
    logic               unit_out_valid;
    logic [N_REQ-1:0]   rsp_valid;
    logic [W-1:0]       rsp_data;
    logic               busy, err_seq;

    logic               inject = 1'b0;
    logic               extra = 1'b0;
    logic [LAT:0]       stub_v;
    logic [W-1:0]       stub_d [0:LAT];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fpu_issue_arbiter #(.N_REQ(N_REQ), .W(W), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(req_valid), .i_req_a(req_a), .i_req_b(req_b),
        .o_req_ready(req_ready), .i_issue_en(issue_en),
        .o_unit_a(unit_a), .o_unit_b(unit_b), .o_unit_valid(unit_valid),
        .i_unit_result(unit_result), .i_unit_out_valid(unit_out_valid),
        .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data),
        .o_busy(busy), .o_err_seq(err_seq)
    );

    function automatic logic [W-1:0] fmodel(input logic [W-1:0] a, input logic [W-1:0] b);
        return a * 32'd3 + b;
    endfunction

    // Stub of the shared unit: fixed LAT pipeline, optionally one stage longer.
    always @(posedge clk) begin
        if (!rst_n) begin
            stub_v <= '0;
            for (int i = 0; i <= LAT; i++) stub_d[i] <= '0;
        end else begin
            stub_v[0] <= unit_valid;
            stub_d[0] <= fmodel(unit_a, unit_b);
            for (int i = 1; i <= LAT; i++) begin
                stub_v[i] <= stub_v[i-1];
                stub_d[i] <= stub_d[i-1];
            end
        end
    end
    assign unit_out_valid = (extra ? stub_v[LAT] : stub_v[LAT-1]) | inject;
    assign unit_result    = extra ? stub_d[LAT] : stub_d[LAT-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        req_valid = '0;
        issue_en  = 1'b1;
        inject    = 1'b0;
        rst_n     = 1'b0;
        @(posedge clk); #1;
        chk("rst_unit_a", 64'(unit_a), 64'h0);
        chk("rst_unit_b", 64'(unit_b), 64'h0);
        chk("rst_unit_valid", 64'(unit_valid), 64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_rsp_data", 64'(rsp_data), 64'h0);
        chk("rst_err_seq", 64'(err_seq), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic       rb;
        logic [1:0] rv;
        logic       en;
        logic [1:0] ready;
        logic       uv;
        logic [1:0] rsp;
        logic       busy;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic rb, input logic [1:0] rv, input logic en, input logic [1:0] ready,
                       input logic uv, input logic [1:0] rsp, input logic bz);
        vec_t v;
        v.rb = rb; v.rv = rv; v.en = en; v.ready = ready; v.uv = uv; v.rsp = rsp; v.busy = bz;
        tbl.push_back(v);
    endtask

    logic [W-1:0] a_op [N_REQ];
    logic [W-1:0] b_op [N_REQ];

    initial begin
        int seen;
        a_op[0] = 32'h3F800000; b_op[0] = 32'h40000000;
        a_op[1] = 32'h11111111; b_op[1] = 32'h22222222;
        req_a = {a_op[1], a_op[0]};
        req_b = {b_op[1], b_op[0]};

        // Both requesters from reset, then issue_en drops and the pipe drains.
        add(1, 2'b11, 1, 2'b01, 0, 2'b00, 0);
        add(0, 2'b11, 1, 2'b10, 1, 2'b00, 1);
        add(0, 2'b11, 1, 2'b01, 1, 2'b00, 1);
        add(0, 2'b11, 1, 2'b10, 1, 2'b00, 1);
        add(0, 2'b11, 1, 2'b01, 1, 2'b00, 1);
        add(0, 2'b11, 1, 2'b10, 1, 2'b00, 1);
        add(0, 2'b11, 0, 2'b00, 1, 2'b01, 1);
        add(0, 2'b11, 0, 2'b00, 0, 2'b10, 1);
        add(0, 2'b11, 0, 2'b00, 0, 2'b01, 1);
        add(0, 2'b11, 0, 2'b00, 0, 2'b10, 1);
        add(0, 2'b11, 0, 2'b00, 0, 2'b01, 1);
        add(0, 2'b11, 0, 2'b00, 0, 2'b10, 0);
        add(0, 2'b11, 0, 2'b00, 0, 2'b00, 0);
        // Lone requester 0 issuing back-to-back for 8 cycles.
        add(1, 2'b01, 1, 2'b01, 0, 2'b00, 0);
        for (int i = 1; i <= 5; i++) add(0, 2'b01, 1, 2'b01, 1, 2'b00, 1);
        add(0, 2'b01, 1, 2'b01, 1, 2'b01, 1);
        add(0, 2'b01, 1, 2'b01, 1, 2'b01, 1);
        add(0, 2'b00, 1, 2'b00, 1, 2'b01, 1);
        for (int i = 9; i <= 12; i++) add(0, 2'b00, 1, 2'b00, 0, 2'b01, 1);
        add(0, 2'b00, 1, 2'b00, 0, 2'b01, 0);
        add(0, 2'b00, 1, 2'b00, 0, 2'b00, 0);

        for (int r = 0; r < tbl.size(); r++) begin
            if (tbl[r].rb) do_reset();
            req_valid = tbl[r].rv;
            issue_en  = tbl[r].en;
            @(negedge clk);
            chk($sformatf("row%0d_req_ready", r), 64'(req_ready), 64'(tbl[r].ready));
            chk($sformatf("row%0d_unit_valid", r), 64'(unit_valid), 64'(tbl[r].uv));
            chk($sformatf("row%0d_rsp_valid", r), 64'(rsp_valid), 64'(tbl[r].rsp));
            chk($sformatf("row%0d_busy", r), 64'(busy), 64'(tbl[r].busy));
            chk($sformatf("row%0d_err_seq", r), 64'(err_seq), 64'h0);
            if (tbl[r].rsp != 2'b00) begin
                int id;
                id = tbl[r].rsp[1] ? 1 : 0;
                chk($sformatf("row%0d_rsp_data", r), 64'(rsp_data), 64'(fmodel(a_op[id], b_op[id])));
            end
            @(posedge clk); #1;
        end

        // Spurious result strobe with nothing in flight.
        do_reset();
        inject = 1'b1;
        @(negedge clk);
        chk("spur_err_before", 64'(err_seq), 64'h0);
        @(posedge clk); #1;
        inject = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("spur_err_sticky%0d", c), 64'(err_seq), 64'h1);
            chk($sformatf("spur_no_rsp%0d", c), 64'(rsp_valid), 64'h0);
            @(posedge clk); #1;
        end

        // Reset with three ops in flight.
        do_reset();
        a_op[0] = 32'hDEADBEEF; a_op[1] = 32'h01234567;
        req_a = {a_op[1], a_op[0]};
        req_valid = 2'b11;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        @(negedge clk);
        chk("midrst_busy_before", 64'(busy), 64'h1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_unit_a", 64'(unit_a), 64'h0);
        chk("midrst_unit_b", 64'(unit_b), 64'h0);
        chk("midrst_unit_valid", 64'(unit_valid), 64'h0);
        chk("midrst_rsp_data", 64'(rsp_data), 64'h0);
        chk("midrst_busy", 64'(busy), 64'h0);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (rsp_valid != 2'b00) seen++;
            @(negedge clk);
        end
        chk("midrst_no_late_rsp", 64'(seen), 64'h0);
        @(posedge clk); #1;

        // Unit one cycle slower than the tag pipe expects.
        do_reset();
        extra = 1'b1;
        req_valid = 2'b10;
        @(negedge clk);
        chk("slow_grant", 64'(req_ready), 64'h2);
        @(posedge clk); #1;
        req_valid = 2'b00;
        seen = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) seen++;
            if (c == 5) chk("slow_err_c5", 64'(err_seq), 64'h0);
            if (c == 6) chk("slow_err_c6", 64'(err_seq), 64'h1);
            @(posedge clk); #1;
        end
        chk("slow_missing_rsp", 64'(1 - seen), 64'h1);
        chk("slow_err_final", 64'(err_seq), 64'h1);
        extra = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
